// File: rtl/ext_mem_arb_pkg.sv
// Shared types and constants for the external memory arbiter slice.
package ext_mem_arb_pkg;

    // Default external memory geometry
    localparam int EXT_ADDR_WIDTH = 20;
    localparam int EXT_DATA_WIDTH = 32;

    typedef logic [EXT_ADDR_WIDTH-1:0] ext_addr_t;
    typedef logic [EXT_DATA_WIDTH-1:0] ext_data_t;

    // Default requester counts
    localparam int NUM_RD_DEFAULT = 3;
    localparam int NUM_WR_DEFAULT = 2;

    // Read client indices
    localparam int RD_FEATURE = 0;
    localparam int RD_KERNEL  = 1;
    localparam int RD_PSUM    = 2;

    // Write client indices
    localparam int WR_PSUM = 0;
    localparam int WR_OUT  = 1;

    // Circular index: (base + offset) mod n, valid for base < n and offset <= n.
    function automatic int rr_wrap(input int base, input int offset, input int n);
        int s;
        s = base + offset;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/ext_mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: pointer register plus combinational one-hot grant.
// cand is the winner ignoring en, so the caller can inspect it (e.g. for an
// address hazard) and then gate the real grant through en.
module rr_arbiter
    import ext_mem_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         arst_n_in,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [N-1:0] cand
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next_ptr;
    logic          w_found;

    // Search requests starting at the pointer; first hit wins
    always_comb begin
        cand       = '0;
        w_found    = 1'b0;
        w_next_ptr = r_ptr;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req[PW'(rr_wrap(int'(r_ptr), k, N))]) begin
                w_found = 1'b1;
                cand[PW'(rr_wrap(int'(r_ptr), k, N))] = 1'b1;
                w_next_ptr = PW'(rr_wrap(int'(r_ptr), k + 1, N));
            end
        end
    end

    assign gnt = en ? cand : '0;

    // Pointer advances past the granted client; holds when nothing is granted
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_ptr <= '0;
        end else if (|gnt) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/ext_mem_arbiter.sv
// Shares one pseudo-2-port external memory between several read and write
// requesters, with independent round-robin arbitration per port, registered
// memory-side signals, tagged read return and bandwidth counters.
//
// Request handshake: a client raises req with addr (and data for writes) and
// holds them stable until it sees its gnt bit high; the transfer is accepted
// in that grant cycle, and the client may change req/addr/data the cycle after.
module ext_mem_arbiter
    import ext_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = EXT_ADDR_WIDTH,
    parameter int DATA_WIDTH = EXT_DATA_WIDTH,
    parameter int NUM_RD     = NUM_RD_DEFAULT,
    parameter int NUM_WR     = NUM_WR_DEFAULT,
    parameter int RD_LATENCY = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         arst_n_in,
    input  logic                         enable,
    input  logic [NUM_RD-1:0]            rd_req,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD-1:0]            rd_gnt,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [NUM_RD-1:0]            rd_data_valid,
    input  logic [NUM_WR-1:0]            wr_req,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_WR-1:0]            wr_gnt,
    output logic [ADDR_WIDTH-1:0]        ext_mem_read_addr,
    output logic                         ext_mem_read_en,
    input  logic [DATA_WIDTH-1:0]        ext_mem_qout,
    output logic [ADDR_WIDTH-1:0]        ext_mem_write_addr,
    output logic                         ext_mem_write_en,
    output logic [DATA_WIDTH-1:0]        ext_mem_din,
    input  logic                         clear_counters,
    output logic [CNT_WIDTH-1:0]         rd_count,
    output logic [CNT_WIDTH-1:0]         wr_count
);

    logic [NUM_RD-1:0]     w_rd_cand;
    logic [NUM_RD-1:0]     w_rd_gnt;
    logic [NUM_WR-1:0]     w_wr_cand;
    logic [NUM_WR-1:0]     w_wr_gnt;
    logic [ADDR_WIDTH-1:0] w_rd_cand_addr;
    logic [ADDR_WIDTH-1:0] w_wr_cand_addr;
    logic [DATA_WIDTH-1:0] w_wr_cand_data;
    logic                  w_hazard;
    logic                  w_rd_en;

    logic [ADDR_WIDTH-1:0] r_read_addr;
    logic                  r_read_en;
    logic [ADDR_WIDTH-1:0] r_write_addr;
    logic                  r_write_en;
    logic [DATA_WIDTH-1:0] r_din;
    logic [NUM_RD-1:0]     r_rd_pipe [RD_LATENCY+1];
    logic [CNT_WIDTH-1:0]  r_rd_count;
    logic [CNT_WIDTH-1:0]  r_wr_count;

    // Write arbiter: granted whenever enable is high
    rr_arbiter #(.N(NUM_WR)) u_wr_arb (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .req       (wr_req),
        .en        (enable),
        .gnt       (w_wr_gnt),
        .cand      (w_wr_cand)
    );

    // Read arbiter: additionally held off for one cycle on a same-address
    // write, so the read lands after the write and returns the new data
    rr_arbiter #(.N(NUM_RD)) u_rd_arb (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .req       (rd_req),
        .en        (w_rd_en),
        .gnt       (w_rd_gnt),
        .cand      (w_rd_cand)
    );

    // One-hot address mux for the read candidate
    always_comb begin
        w_rd_cand_addr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (w_rd_cand[i]) begin
                w_rd_cand_addr = w_rd_cand_addr | rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // One-hot address/data mux for the write candidate
    always_comb begin
        w_wr_cand_addr = '0;
        w_wr_cand_data = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (w_wr_cand[i]) begin
                w_wr_cand_addr = w_wr_cand_addr | wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_wr_cand_data = w_wr_cand_data | wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Hazard only when a write is actually granted to the read winner's address
    assign w_hazard = (|w_wr_gnt) && (|w_rd_cand) && (w_rd_cand_addr == w_wr_cand_addr);
    assign w_rd_en  = enable && !w_hazard;

    // Read port register: address holds its last value while idle
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_read_en   <= 1'b0;
            r_read_addr <= '0;
        end else begin
            r_read_en <= |w_rd_gnt;
            if (|w_rd_gnt) begin
                r_read_addr <= w_rd_cand_addr;
            end
        end
    end

    // Write port register: address and data hold their last value while idle
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_write_en   <= 1'b0;
            r_write_addr <= '0;
            r_din        <= '0;
        end else begin
            r_write_en <= |w_wr_gnt;
            if (|w_wr_gnt) begin
                r_write_addr <= w_wr_cand_addr;
                r_din        <= w_wr_cand_data;
            end
        end
    end

    // Grant tag pipeline: stage 0 lines up with read_en, the last stage
    // lines up with qout; reset discards anything in flight
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            for (int k = 0; k <= RD_LATENCY; k++) begin
                r_rd_pipe[k] <= '0;
            end
        end else begin
            r_rd_pipe[0] <= w_rd_gnt;
            for (int k = 1; k <= RD_LATENCY; k++) begin
                r_rd_pipe[k] <= r_rd_pipe[k-1];
            end
        end
    end

    // Saturating read word counter; clear takes priority over increment
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_rd_count <= '0;
        end else if (clear_counters) begin
            r_rd_count <= '0;
        end else if (r_read_en && (r_rd_count != '1)) begin
            r_rd_count <= r_rd_count + CNT_WIDTH'(1);
        end
    end

    // Saturating write word counter; clear takes priority over increment
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_wr_count <= '0;
        end else if (clear_counters) begin
            r_wr_count <= '0;
        end else if (r_write_en && (r_wr_count != '1)) begin
            r_wr_count <= r_wr_count + CNT_WIDTH'(1);
        end
    end

    assign rd_gnt             = w_rd_gnt;
    assign wr_gnt             = w_wr_gnt;
    assign ext_mem_read_en    = r_read_en;
    assign ext_mem_read_addr  = r_read_addr;
    assign ext_mem_write_en   = r_write_en;
    assign ext_mem_write_addr = r_write_addr;
    assign ext_mem_din        = r_din;
    assign rd_data            = ext_mem_qout;
    assign rd_data_valid      = r_rd_pipe[RD_LATENCY];
    assign rd_count           = r_rd_count;
    assign wr_count           = r_wr_count;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Self-checking bench for ext_mem_arbiter: reset checks, a combinational
// grant table, directed multi-cycle sequences and a randomized run, all
// compared against a transaction-level model of the arbiter.
module tb_ext_mem_arbiter;
    import ext_mem_arb_pkg::*;

    localparam int AW  = 20;
    localparam int DW  = 32;
    localparam int NR  = 3;
    localparam int NW  = 2;
    localparam int LAT = 1;
    localparam int CW  = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              arst_n_in;
    logic              enable;
    logic [NR-1:0]     rd_req;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR-1:0]     rd_gnt;
    logic [DW-1:0]     rd_data;
    logic [NR-1:0]     rd_data_valid;
    logic [NW-1:0]     wr_req;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic [NW-1:0]     wr_gnt;
    logic [AW-1:0]     ext_mem_read_addr;
    logic              ext_mem_read_en;
    logic [DW-1:0]     ext_mem_qout = '0;
    logic [AW-1:0]     ext_mem_write_addr;
    logic              ext_mem_write_en;
    logic [DW-1:0]     ext_mem_din;
    logic              clear_counters;
    logic [CW-1:0]     rd_count;
    logic [CW-1:0]     wr_count;

    ext_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW),
        .RD_LATENCY(LAT), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .arst_n_in(arst_n_in), .enable(enable),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .ext_mem_read_addr(ext_mem_read_addr), .ext_mem_read_en(ext_mem_read_en),
        .ext_mem_qout(ext_mem_qout), .ext_mem_write_addr(ext_mem_write_addr),
        .ext_mem_write_en(ext_mem_write_en), .ext_mem_din(ext_mem_din),
        .clear_counters(clear_counters), .rd_count(rd_count), .wr_count(wr_count)
    );

    // ---------------- external memory (1-cycle read latency) ----------------
    function automatic ext_data_t mem_init(input logic [AW-1:0] a);
        return {12'hA5C, a};
    endfunction

    ext_data_t env_mem [int];

    always @(posedge clk) begin
        if (ext_mem_read_en) begin
            ext_mem_qout <= env_mem.exists(int'(ext_mem_read_addr)) ?
                            env_mem[int'(ext_mem_read_addr)] : mem_init(ext_mem_read_addr);
        end
        if (ext_mem_write_en) begin
            env_mem[int'(ext_mem_write_addr)] = ext_mem_din;
        end
    end

    // ---------------- scoreboard / reference model ----------------
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int        due;
        int        client;
        ext_data_t data;
    } ret_t;

    ret_t      ret_q[$];
    ext_data_t shadow [int];
    int        m_rd_ptr, m_wr_ptr, m_cyc;
    logic      m_re, m_we;
    logic [AW-1:0] m_ra, m_wa;
    ext_data_t m_din;
    int        m_rc, m_wc;
    int        m_last_ri, m_last_wi;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] req, input int ptr, input int n);
        for (int k = 0; k < n; k++) begin
            if (req[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    function automatic logic [7:0] onehot(input int i);
        logic [7:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic ext_data_t shadow_rd(input logic [AW-1:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : mem_init(a);
    endfunction

    task automatic model_reset();
        m_rd_ptr = 0; m_wr_ptr = 0;
        m_re = 1'b0; m_we = 1'b0;
        m_ra = '0; m_wa = '0; m_din = '0;
        m_rc = 0; m_wc = 0;
        m_last_ri = -1; m_last_wi = -1;
        ret_q.delete();
    endtask

    // One clock cycle: inputs are already driven; compare at the falling
    // edge, advance the model, then return just after the next rising edge.
    task automatic run_cycle();
        int ri, wi;
        logic [AW-1:0] ra, wa;
        ext_data_t wd, exp_d;
        logic [NR-1:0] exp_v;
        ra = '0; wa = '0; wd = '0; exp_d = '0;
        @(negedge clk);
        ri = -1; wi = -1;
        if (enable) begin
            ri = pick(8'(rd_req), m_rd_ptr, NR);
            wi = pick(8'(wr_req), m_wr_ptr, NW);
        end
        if (ri >= 0) ra = rd_addr[ri*AW +: AW];
        if (wi >= 0) begin
            wa = wr_addr[wi*AW +: AW];
            wd = wr_data[wi*DW +: DW];
        end
        if (ri >= 0 && wi >= 0 && ra == wa) ri = -1;

        exp_v = '0;
        if (ret_q.size() > 0 && ret_q[0].due == m_cyc) begin
            exp_v[ret_q[0].client] = 1'b1;
            exp_d = ret_q[0].data;
        end

        chk("rd_gnt", 64'(rd_gnt), 64'(onehot(ri)));
        chk("wr_gnt", 64'(wr_gnt), 64'(onehot(wi)));
        chk("rd_data_valid", 64'(rd_data_valid), 64'(exp_v));
        if (exp_v != '0) chk("rd_data", 64'(rd_data), 64'(exp_d));
        chk("read_en", 64'(ext_mem_read_en), 64'(m_re));
        chk("read_addr", 64'(ext_mem_read_addr), 64'(m_ra));
        chk("write_en", 64'(ext_mem_write_en), 64'(m_we));
        chk("write_addr", 64'(ext_mem_write_addr), 64'(m_wa));
        chk("din", 64'(ext_mem_din), 64'(m_din));
        chk("rd_count", 64'(rd_count), 64'(m_rc));
        chk("wr_count", 64'(wr_count), 64'(m_wc));

        if (exp_v != '0) void'(ret_q.pop_front());
        m_rc = clear_counters ? 0 : ((m_re && m_rc < CNT_MAX) ? m_rc + 1 : m_rc);
        m_wc = clear_counters ? 0 : ((m_we && m_wc < CNT_MAX) ? m_wc + 1 : m_wc);
        m_re = (ri >= 0);
        if (ri >= 0) begin
            m_ra = ra;
            ret_q.push_back('{m_cyc + 1 + LAT, ri, shadow_rd(ra)});
            m_rd_ptr = (ri + 1) % NR;
        end
        m_we = (wi >= 0);
        if (wi >= 0) begin
            m_wa  = wa;
            m_din = wd;
            shadow[int'(wa)] = wd;
            m_wr_ptr = (wi + 1) % NW;
        end
        m_last_ri = ri;
        m_last_wi = wi;
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        rd_req = '0; wr_req = '0; enable = 1'b1; clear_counters = 1'b0;
    endtask

    // Leaves the bench just after a rising edge with reset released
    task automatic do_reset();
        arst_n_in = 1'b0;
        idle_inputs();
        #1;
        model_reset();
        @(posedge clk);
        #1;
        arst_n_in = 1'b1;
    endtask

    task automatic drive_random();
        for (int i = 0; i < NR; i++) begin
            if (!rd_req[i] || m_last_ri == i) begin
                rd_req[i] = ($urandom_range(0, 99) < 55);
                if (rd_req[i]) rd_addr[i*AW +: AW] = 20'h40 + AW'($urandom_range(0, 7));
            end
        end
        for (int i = 0; i < NW; i++) begin
            if (!wr_req[i] || m_last_wi == i) begin
                wr_req[i] = ($urandom_range(0, 99) < 45);
                if (wr_req[i]) begin
                    wr_addr[i*AW +: AW] = 20'h40 + AW'($urandom_range(0, 7));
                    wr_data[i*DW +: DW] = DW'($urandom());
                end
            end
        end
        enable         = ($urandom_range(0, 9) != 0);
        clear_counters = ($urandom_range(0, 29) == 0);
    endtask

    // ---------------- grant table (applied while reset holds pointers at 0) ----------------
    typedef struct {
        logic             en;
        logic [NR-1:0]    rrq;
        logic [NR*AW-1:0] ra;
        logic [NW-1:0]    wrq;
        logic [NW*AW-1:0] wa;
        logic [NR-1:0]    exp_rg;
        logic [NW-1:0]    exp_wg;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b1, 3'b010, {20'h3,  20'h123, 20'h1 }, 2'b00, {20'h0,  20'h0 }, 3'b010, 2'b00};
        vecs[1] = '{1'b1, 3'b111, {20'h30, 20'h20,  20'h10}, 2'b11, {20'h50, 20'h40}, 3'b001, 2'b01};
        vecs[2] = '{1'b0, 3'b111, {20'h30, 20'h20,  20'h10}, 2'b11, {20'h50, 20'h40}, 3'b000, 2'b00};
        vecs[3] = '{1'b1, 3'b100, {20'h40, 20'h0,   20'h0 }, 2'b01, {20'h0,  20'h40}, 3'b000, 2'b01};
        vecs[4] = '{1'b1, 3'b101, {20'h50, 20'h0,   20'h40}, 2'b10, {20'h40, 20'h0 }, 3'b000, 2'b10};
        vecs[5] = '{1'b1, 3'b110, {20'h0,  20'h40,  20'h0 }, 2'b10, {20'h41, 20'h0 }, 3'b010, 2'b10};
        vecs[6] = '{1'b1, 3'b000, {20'h0,  20'h0,   20'h0 }, 2'b00, {20'h0,  20'h0 }, 3'b000, 2'b00};
        vecs[7] = '{1'b1, 3'b100, {20'h40, 20'h0,   20'h0 }, 2'b00, {20'h0,  20'h0 }, 3'b100, 2'b00};

        rd_addr = '0; wr_addr = '0; wr_data = '0;
        arst_n_in = 1'b0;
        idle_inputs();
        model_reset();
        m_cyc = 0;
        #12;

        // Reset state
        chk("rst read_en", 64'(ext_mem_read_en), 64'd0);
        chk("rst write_en", 64'(ext_mem_write_en), 64'd0);
        chk("rst read_addr", 64'(ext_mem_read_addr), 64'd0);
        chk("rst write_addr", 64'(ext_mem_write_addr), 64'd0);
        chk("rst din", 64'(ext_mem_din), 64'd0);
        chk("rst valid", 64'(rd_data_valid), 64'd0);
        chk("rst rd_count", 64'(rd_count), 64'd0);
        chk("rst wr_count", 64'(wr_count), 64'd0);

        // Combinational grant table
        for (int v = 0; v < 8; v++) begin
            enable = vecs[v].en; rd_req = vecs[v].rrq; rd_addr = vecs[v].ra;
            wr_req = vecs[v].wrq; wr_addr = vecs[v].wa;
            #1;
            chk($sformatf("table%0d rd_gnt", v), 64'(rd_gnt), 64'(vecs[v].exp_rg));
            chk($sformatf("table%0d wr_gnt", v), 64'(wr_gnt), 64'(vecs[v].exp_wg));
        end

        // Single read from the kernel client
        do_reset();
        rd_req[RD_KERNEL] = 1'b1;
        rd_addr[RD_KERNEL*AW +: AW] = 20'h00123;
        #1 chk("single gnt", 64'(rd_gnt), 64'b010);
        run_cycle();
        rd_req = '0;
        #1 chk("single read_en", 64'(ext_mem_read_en), 64'd1);
        chk("single read_addr", 64'(ext_mem_read_addr), 64'h123);
        run_cycle();
        #1 chk("single valid", 64'(rd_data_valid), 64'b010);
        chk("single data", 64'(rd_data), 64'hA5C00123);
        chk("single rd_count", 64'(rd_count), 64'd1);
        run_cycle();

        // Round robin across three readers
        do_reset();
        rd_req = 3'b111;
        rd_addr = {20'h300, 20'h200, 20'h100};
        for (int k = 0; k < 6; k++) begin
            #1 chk($sformatf("rr gnt%0d", k), 64'(rd_gnt), 64'(1 << (k % 3)));
            run_cycle();
        end
        rd_req = '0;
        run_cycle();
        run_cycle();
        #1 chk("rr rd_count", 64'(rd_count), 64'd6);

        // Concurrent read and write to different addresses
        do_reset();
        rd_req[RD_FEATURE] = 1'b1; rd_addr[RD_FEATURE*AW +: AW] = 20'h10;
        wr_req[WR_OUT] = 1'b1; wr_addr[WR_OUT*AW +: AW] = 20'h20;
        wr_data[WR_OUT*DW +: DW] = 32'hDEADBEEF;
        #1 chk("conc rd_gnt", 64'(rd_gnt), 64'b001);
        chk("conc wr_gnt", 64'(wr_gnt), 64'b10);
        run_cycle();
        rd_req = '0; wr_req = '0;
        #1 chk("conc both_en", 64'({ext_mem_read_en, ext_mem_write_en}), 64'b11);
        chk("conc write_addr", 64'(ext_mem_write_addr), 64'h20);
        chk("conc din", 64'(ext_mem_din), 64'hDEADBEEF);
        run_cycle();
        #1 chk("conc counts", 64'({rd_count, wr_count}), 64'h11);
        run_cycle();

        // Same-address hazard: write first, read next cycle sees new data
        do_reset();
        wr_req[WR_PSUM] = 1'b1; wr_addr[WR_PSUM*AW +: AW] = 20'h40;
        wr_data[WR_PSUM*DW +: DW] = 32'hCAFEF00D;
        rd_req[RD_FEATURE] = 1'b1; rd_addr[RD_FEATURE*AW +: AW] = 20'h40;
        #1 chk("haz wr_gnt", 64'(wr_gnt), 64'b01);
        chk("haz rd_gnt0", 64'(rd_gnt), 64'b000);
        run_cycle();
        wr_req = '0;
        #1 chk("haz rd_gnt1", 64'(rd_gnt), 64'b001);
        run_cycle();
        rd_req = '0;
        run_cycle();
        #1 chk("haz valid", 64'(rd_data_valid), 64'b001);
        chk("haz data", 64'(rd_data), 64'hCAFEF00D);
        run_cycle();

        // enable drop with an in-flight read
        do_reset();
        rd_req = 3'b011;
        rd_addr = {20'h0, 20'h51, 20'h50};
        #1 chk("en gnt0", 64'(rd_gnt), 64'b001);
        run_cycle();
        enable = 1'b0;
        #1 chk("en off gnt", 64'(rd_gnt), 64'b000);
        run_cycle();
        #1 chk("en off gnt2", 64'(rd_gnt), 64'b000);
        chk("en inflight valid", 64'(rd_data_valid), 64'b001);
        run_cycle();
        enable = 1'b1;
        #1 chk("en resume gnt", 64'(rd_gnt), 64'b010);
        run_cycle();
        rd_req = '0;
        for (int k = 0; k < 3; k++) run_cycle();

        // Counter saturation and clear-over-increment
        do_reset();
        rd_req[RD_FEATURE] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rd_addr[RD_FEATURE*AW +: AW] = 20'h100 + AW'(k);
            run_cycle();
        end
        rd_req = '0;
        #1 chk("sat rd_count", 64'(rd_count), 64'd15);
        chk("sat read_en", 64'(ext_mem_read_en), 64'd1);
        clear_counters = 1'b1;
        run_cycle();
        clear_counters = 1'b0;
        #1 chk("clear rd_count", 64'(rd_count), 64'd0);
        for (int k = 0; k < 3; k++) run_cycle();

        // Reset with a read in flight
        do_reset();
        rd_req[RD_PSUM] = 1'b1; rd_addr[RD_PSUM*AW +: AW] = 20'h77;
        run_cycle();
        rd_req = '0;
        arst_n_in = 1'b0;
        #1;
        model_reset();
        chk("midrst read_en", 64'(ext_mem_read_en), 64'd0);
        chk("midrst read_addr", 64'(ext_mem_read_addr), 64'd0);
        chk("midrst valid", 64'(rd_data_valid), 64'd0);
        chk("midrst rd_count", 64'(rd_count), 64'd0);
        @(posedge clk);
        #1;
        arst_n_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_cycle();
            chk($sformatf("midrst no valid%0d", k), 64'(rd_data_valid), 64'd0);
        end

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) do_reset();
            drive_random();
            run_cycle();
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) run_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Time bound for the whole run
    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time bound");
        $fatal(1);
    end

endmodule

// File: doc/ext_mem_arbiter.md
Name: ext_mem_arbiter

Overview:
- Shares the single pseudo-2-port external memory (one read port, one write port per cycle) between several on-chip requesters inside top_chip.
- Typical requesters: feature-map fetch, kernel fetch, partial-sum readback/writeback.
- Arbitrates reads and writes independently with round-robin, registers the memory-side signals, and routes read data back with a one-hot valid tag.
- Counts read and write words, since all traffic in and out of top_chip is bandwidth-accounted.

Parameters:
- ADDR_WIDTH, 20, external memory address width (clog2 of EXT_MEM_HEIGHT).
- DATA_WIDTH, 32, external memory word width (EXT_MEM_WIDTH).
- NUM_RD, 3, number of read requesters (2..8).
- NUM_WR, 2, number of write requesters (2..8).
- RD_LATENCY, 1, memory cycles from read_en to qout valid.
- CNT_WIDTH, 32, width of the bandwidth counters.

Ports:
- clk  in  1  clock.
- arst_n_in  in  1  reset, asynchronous, active-low.
- enable  in  1  when low, no new grants are issued.
- rd_req  in  NUM_RD  per-client read request (level).
- rd_addr  in  NUM_RD*ADDR_WIDTH  flattened per-client read address; client i uses slice i.
- rd_gnt  out  NUM_RD  one-hot combinational read grant.
- rd_data  out  DATA_WIDTH  returned read word.
- rd_data_valid  out  NUM_RD  one-hot tag: rd_data belongs to client i.
- wr_req  in  NUM_WR  per-client write request.
- wr_addr  in  NUM_WR*ADDR_WIDTH  flattened write addresses.
- wr_data  in  NUM_WR*DATA_WIDTH  flattened write data.
- wr_gnt  out  NUM_WR  one-hot combinational write grant.
- ext_mem_read_addr  out  ADDR_WIDTH  to memory.
- ext_mem_read_en  out  1  to memory.
- ext_mem_qout  in  DATA_WIDTH  from memory.
- ext_mem_write_addr  out  ADDR_WIDTH  to memory.
- ext_mem_write_en  out  1  to memory.
- ext_mem_din  out  DATA_WIDTH  to memory.
- clear_counters  in  1  synchronous counter clear.
- rd_count  out  CNT_WIDTH  words read since reset or clear.
- wr_count  out  CNT_WIDTH  words written since reset or clear.

Behaviour:

Reset:
- All registered outputs go to 0: ext_mem_* enables, addresses, din, rd_data_valid pipeline, rd_count, wr_count.
- Both round-robin pointers go to 0.

Grant:
- Combinational; at most one rd_gnt and one wr_gnt per cycle.
- A client is granted only if its req is high and enable is high.
- Round-robin search starts at the pointer. After granting client i, pointer <= (i+1) mod N. The pointer does not move when nothing is granted.
- A client holds req, addr and data stable until its grant. Request handshake completes in the grant cycle. The client may change addr/req in the next cycle.

Memory side (registered, one cycle after grant):
- ext_mem_read_en <= |rd_gnt; ext_mem_read_addr <= granted addr.
- Write side mirrors this with write_en/addr/din.
- When idle, enables drop to 0 and addr/din hold their last value.

Read return:
- The one-hot grant shifts through a (1+RD_LATENCY)-stage pipeline.
- rd_data_valid asserts exactly 1+RD_LATENCY cycles after the grant cycle.
- rd_data = ext_mem_qout (combinational passthrough).
- Back-to-back grants yield back-to-back returns in grant order; full throughput is one read and one write per cycle.

Same-address hazard:
- If the granted write and the winning read candidate share an address in the same cycle, the read grant is withheld that cycle; the write proceeds.
- The read pointer is unchanged, so the read wins next cycle and returns the new data.

enable low:
- Grants stop immediately.
- In-flight reads still complete and still assert rd_data_valid.

Counters:
- rd_count increments in every cycle ext_mem_read_en=1; wr_count in every cycle ext_mem_write_en=1.
- Both saturate at all-ones.
- clear_counters sets both to 0 next cycle; clear wins over a same-cycle increment.

Reset mid-operation:
- Pending returns are discarded; no rd_data_valid follows reset.

Decomposition:
- Package ext_mem_arb_pkg holds: the addr/data typedefs sized from ADDR_WIDTH/DATA_WIDTH, the default NUM_RD/NUM_WR constants, and client index constants (RD_FEATURE=0, RD_KERNEL=1, RD_PSUM=2, WR_PSUM=0, WR_OUT=1).
- Sub-module rr_arbiter (parameter N; ports clk, arst_n_in, req, en, gnt): pointer register plus combinational grant.
- rr_arbiter is instantiated twice, once for reads and once for writes. The hazard mask is applied to the read arbiter's en input.

Test Plan:
- Single read: rd_req=3'b010 at cycle 0, addr 0x00123 -> rd_gnt=010 at cycle 0; read_en=1 with addr 0x00123 at cycle 1; rd_data_valid=010 at cycle 2 carrying mem[0x123]; rd_count=1.
- Round robin: all three read reqs held high for 6 cycles from reset -> grant order 0,1,2,0,1,2; returns tagged in the same order; rd_count=6.
- Concurrent read/write to different addresses: read client 0 at 0x10 and write client 1 at 0x20 with data 0xDEADBEEF in the same cycle -> both granted; read_en and write_en both high next cycle; rd_count=1, wr_count=1.
- Hazard: write 0xCAFEF00D and read both at 0x40 in the same cycle -> wr_gnt asserted, rd_gnt=0; read granted the next cycle; returned data = 0xCAFEF00D.
- enable drop: enable=0 one cycle after a read grant, with reqs held -> no further grants; the in-flight rd_data_valid still arrives; grants resume on the first cycle with enable=1.
- Counters/reset: CNT_WIDTH=4 with 20 reads -> rd_count saturates at 15. clear_counters together with a read -> 0. arst_n_in pulsed with one read in flight -> no rd_data_valid afterwards and all outputs 0.
